// File: rtl/gated_alu_pkg.sv
// Shared opcode encoding and flag-vector layout for the gated ALU pipeline.
package gated_alu_pkg;

    typedef enum logic [7:0] {
        OP_ADD  = 8'h00,
        OP_SUB  = 8'h01,
        OP_ADDC = 8'h02,
        OP_SUBB = 8'h03,
        OP_SHL1 = 8'h04,
        OP_SHR1 = 8'h05,
        OP_ROL1 = 8'h06,
        OP_ROR1 = 8'h07,
        OP_AND  = 8'h08,
        OP_OR   = 8'h09,
        OP_XOR  = 8'h0A,
        OP_NOR  = 8'h0B,
        OP_NAND = 8'h0C,
        OP_XNOR = 8'h0D,
        OP_GT   = 8'h0E,
        OP_EQ   = 8'h0F
    } alu_op_e;

    localparam int FLG_CARRY   = 0;
    localparam int FLG_ZERO    = 1;
    localparam int FLG_NEG     = 2;
    localparam int FLG_OVF     = 3;
    localparam int FLG_ILLEGAL = 4;
    localparam int FLAG_W      = 5;

endpackage

// File: rtl/alu_core_comb.sv
// Purely combinational ALU: one result plus carry/zero/neg/overflow/illegal flags.
module alu_core_comb
    import gated_alu_pkg::*;
#(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    input  logic [7:0]        i_sel,
    input  logic              i_cq,
    output logic [WIDTH-1:0]  o_res,
    output logic [FLAG_W-1:0] o_flags
);

    logic [WIDTH-1:0] w_b_op;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic             w_carry;
    logic             w_ovf;
    logic             w_ill;

    // All four add/sub opcodes share one adder; subtraction feeds ~B.
    always_comb begin
        w_b_op = i_b;
        w_cin  = 1'b0;
        case (i_sel)
            OP_SUB:  begin w_b_op = ~i_b; w_cin = 1'b1; end
            OP_ADDC: w_cin = i_cq;
            OP_SUBB: begin w_b_op = ~i_b; w_cin = i_cq; end
            default: ;
        endcase
    end

    assign w_sum = {1'b0, i_a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_cin};

    always_comb begin
        o_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_ill   = 1'b0;
        case (i_sel)
            OP_ADD, OP_SUB, OP_ADDC, OP_SUBB: begin
                o_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = (i_a[WIDTH-1] == w_b_op[WIDTH-1]) &&
                          (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SHL1: begin o_res = {i_a[WIDTH-2:0], 1'b0};          w_carry = i_a[WIDTH-1]; end
            OP_SHR1: begin o_res = {1'b0, i_a[WIDTH-1:1]};          w_carry = i_a[0];       end
            OP_ROL1: begin o_res = {i_a[WIDTH-2:0], i_a[WIDTH-1]};  w_carry = i_a[WIDTH-1]; end
            OP_ROR1: begin o_res = {i_a[0], i_a[WIDTH-1:1]};        w_carry = i_a[0];       end
            OP_AND:  o_res = i_a & i_b;
            OP_OR:   o_res = i_a | i_b;
            OP_XOR:  o_res = i_a ^ i_b;
            OP_NOR:  o_res = ~(i_a | i_b);
            OP_NAND: o_res = ~(i_a & i_b);
            OP_XNOR: o_res = ~(i_a ^ i_b);
            OP_GT:   o_res = {{(WIDTH-1){1'b0}}, (i_a > i_b)};
            OP_EQ:   o_res = {{(WIDTH-1){1'b0}}, (i_a == i_b)};
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        o_flags              = '0;
        o_flags[FLG_CARRY]   = w_carry;
        o_flags[FLG_OVF]     = w_ovf;
        o_flags[FLG_ILLEGAL] = w_ill;
        o_flags[FLG_ZERO]    = !w_ill && (o_res == '0);
        o_flags[FLG_NEG]     = !w_ill && o_res[WIDTH-1];
    end

endmodule

// File: rtl/gated_alu_pipe.sv
// Two-stage ALU pipeline (operand register, result register) with a registered
// enable that stalls both stages while still letting a pending result drain.
module gated_alu_pipe
    import gated_alu_pkg::*;
#(
    parameter int WIDTH = 256
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENABLE,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] AIN,
    input  logic [WIDTH-1:0] BIN,
    input  logic [7:0]       ALU_SEL,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             CARRYOUT,
    output logic             ZERO,
    output logic             NEG,
    output logic             OVF,
    output logic             ILLEGAL
);

    logic              r_en_q;
    logic              r_vld_p1;
    logic [WIDTH-1:0]  r_a_p1;
    logic [WIDTH-1:0]  r_b_p1;
    logic [7:0]        r_sel_p1;
    logic              r_vld_p2;
    logic [WIDTH-1:0]  r_res_p2;
    logic [FLAG_W-1:0] r_flags_p2;
    logic              r_cq_p2;

    logic              w_s2_adv;
    logic              w_in_fire;
    logic              w_out_fire;
    logic [WIDTH-1:0]  w_res;
    logic [FLAG_W-1:0] w_flags;

    assign w_s2_adv   = r_en_q && r_vld_p1 && (!r_vld_p2 || OUT_READY);
    assign IN_READY   = r_en_q && (!r_vld_p1 || w_s2_adv);
    assign w_in_fire  = IN_VALID && IN_READY;
    assign w_out_fire = r_vld_p2 && OUT_READY;

    always_ff @(posedge CLK) begin
        if (!RST_N) r_en_q <= 1'b0;
        else        r_en_q <= ENABLE;
    end

    // Stage 1: operand capture
    always_ff @(posedge CLK) begin
        if (!RST_N)         r_vld_p1 <= 1'b0;
        else if (w_in_fire) r_vld_p1 <= 1'b1;
        else if (w_s2_adv)  r_vld_p1 <= 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (w_in_fire) begin
            r_a_p1   <= AIN;
            r_b_p1   <= BIN;
            r_sel_p1 <= ALU_SEL;
        end
    end

    alu_core_comb #(.WIDTH(WIDTH)) u_core (
        .i_a     (r_a_p1),
        .i_b     (r_b_p1),
        .i_sel   (r_sel_p1),
        .i_cq    (r_cq_p2),
        .o_res   (w_res),
        .o_flags (w_flags)
    );

    // Stage 2: result register; cq follows whatever carry was last loaded
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_vld_p2   <= 1'b0;
            r_res_p2   <= '0;
            r_flags_p2 <= '0;
            r_cq_p2    <= 1'b0;
        end else if (w_s2_adv) begin
            r_vld_p2   <= 1'b1;
            r_res_p2   <= w_res;
            r_flags_p2 <= w_flags;
            r_cq_p2    <= w_flags[FLG_CARRY];
        end else if (w_out_fire) begin
            r_vld_p2   <= 1'b0;
        end
    end

    assign OUT_VALID = r_vld_p2;
    assign ALU_OUT   = r_res_p2;
    assign CARRYOUT  = r_flags_p2[FLG_CARRY];
    assign ZERO      = r_flags_p2[FLG_ZERO];
    assign NEG       = r_flags_p2[FLG_NEG];
    assign OVF       = r_flags_p2[FLG_OVF];
    assign ILLEGAL   = r_flags_p2[FLG_ILLEGAL];

endmodule

// File: tb/tb_gated_alu_pipe.sv
// Randomized and directed bench for gated_alu_pipe at WIDTH=8 with an in-order scoreboard.
module tb_gated_alu_pipe;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         ENABLE;
    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] AIN;
    logic [W-1:0] BIN;
    logic [7:0]   ALU_SEL;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] ALU_OUT;
    logic         CARRYOUT, ZERO, NEG, OVF, ILLEGAL;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    gated_alu_pipe #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .ENABLE    (ENABLE),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .AIN       (AIN),
        .BIN       (BIN),
        .ALU_SEL   (ALU_SEL),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .ALU_OUT   (ALU_OUT),
        .CARRYOUT  (CARRYOUT),
        .ZERO      (ZERO),
        .NEG       (NEG),
        .OVF       (OVF),
        .ILLEGAL   (ILLEGAL)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Result packed as {ILLEGAL, OVF, NEG, ZERO, CARRYOUT, ALU_OUT[7:0]}
    function automatic logic [12:0] model(input int a, input int b, input int sel, input int cq);
        int r, s, sa, sb;
        logic c, o, ill, z, n;
        r = 0; s = 0; c = 0; o = 0; ill = 0;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        case (sel)
            0:  begin r = a + b;              s = sa + sb;          end
            1:  begin r = a + (255 - b) + 1;  s = sa - sb;          end
            2:  begin r = a + b + cq;         s = sa + sb + cq;     end
            3:  begin r = a + (255 - b) + cq; s = sa - sb - 1 + cq; end
            4:  begin r = (a * 2) % 256;           c = (a / 128) != 0; end
            5:  begin r = a / 2;                   c = (a % 2) != 0;   end
            6:  begin r = (a * 2) % 256 + a / 128; c = (a / 128) != 0; end
            7:  begin r = a / 2 + (a % 2) * 128;   c = (a % 2) != 0;   end
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = 255 - (a | b);
            12: r = 255 - (a & b);
            13: r = 255 - (a ^ b);
            14: r = (a > b) ? 1 : 0;
            15: r = (a == b) ? 1 : 0;
            default: ill = 1;
        endcase
        if (sel <= 3) begin
            c = (r > 255);
            r = r % 256;
            o = (s > 127) || (s < -128);
        end
        z = !ill && (r == 0);
        n = !ill && (r >= 128);
        return {ill, o, n, z, c, r[7:0]};
    endfunction

    logic [12:0] obs;
    assign obs = {ILLEGAL, OVF, NEG, ZERO, CARRYOUT, ALU_OUT};

    logic [12:0] q[$];
    int          mcq = 0;
    logic        hold_v = 1'b0;
    logic [12:0] hold_val = '0;

    always @(negedge CLK) begin
        if (RST_N !== 1'b1) begin
            q.delete();
            mcq = 0;
            hold_v = 1'b0;
        end else begin
            if (hold_v) chk("hold_stable", {OUT_VALID, obs}, {1'b1, hold_val});
            if (OUT_VALID && OUT_READY) begin
                if (q.size() == 0) chk("spurious_out", 1, 0);
                else chk("sb_result", obs, q.pop_front());
            end
            if (IN_VALID && IN_READY) begin
                logic [12:0] e;
                e = model(int'(AIN), int'(BIN), int'(ALU_SEL), mcq);
                mcq = int'(e[8]);
                q.push_back(e);
            end
            hold_v   = OUT_VALID && !OUT_READY;
            hold_val = obs;
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic new_beat();
        AIN     = W'($urandom);
        BIN     = W'($urandom);
        ALU_SEL = 8'($urandom_range(0, 18));
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] sel);
        logic acc;
        AIN = a; BIN = b; ALU_SEL = sel; IN_VALID = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge CLK);
            acc = IN_READY;
            step();
        end
        IN_VALID = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic expect_out(input string tag, input logic [12:0] exp);
        for (int t = 0; t < 4 && !OUT_VALID; t++) step();
        chk({tag, "_vld"}, OUT_VALID, 1);
        chk({tag, "_val"}, obs, exp);
    endtask

    task automatic fill2();
        int   got;
        logic f;
        got = 0;
        IN_VALID = 1'b1;
        new_beat();
        for (int t = 0; t < 20 && got < 2; t++) begin
            @(negedge CLK);
            f = IN_READY;
            step();
            if (f) begin got++; new_beat(); end
        end
        IN_VALID = 1'b0;
        if (got < 2) chk("fill_timeout", got, 2);
    endtask

    task automatic stream(input int n);
        logic f;
        IN_VALID = 1'b1;
        for (int t = 0; t < n; t++) begin
            @(negedge CLK);
            f = IN_READY;
            step();
            if (f) new_beat();
        end
        IN_VALID = 1'b0;
    endtask

    task automatic drain();
        ENABLE = 1'b1; OUT_READY = 1'b1; IN_VALID = 1'b0;
        repeat (6) step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

    initial begin
        logic f;
        RST_N = 1'b0; ENABLE = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b1;
        AIN = '0; BIN = '0; ALU_SEL = '0;
        repeat (3) step();
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_outputs", obs, 0);
        chk("rst_in_ready", IN_READY, 0);
        RST_N = 1'b1;
        chk("rdy_first_cycle", IN_READY, 0);
        step();
        chk("rdy_second_cycle", IN_READY, 1);

        // ADD 0xFF+0x01 with explicit latency
        send(8'hFF, 8'h01, 8'h00);
        chk("lat_s1_only", OUT_VALID, 0);
        step();
        chk("lat_out_valid", OUT_VALID, 1);
        chk("add_wrap", obs, {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00});
        step();

        // carry chain
        send(8'hFF, 8'h01, 8'h00);
        expect_out("chain_add", {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00});
        send(8'h00, 8'h00, 8'h02);
        expect_out("chain_addc", {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01});
        send(8'h00, 8'h01, 8'h01);
        expect_out("sub_borrow", {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF});

        // illegal opcode clears cq
        send(8'hFF, 8'h01, 8'h00);
        expect_out("pre_ill_add", {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00});
        send(8'hFF, 8'hFF, 8'h10);
        expect_out("illegal", {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
        send(8'h00, 8'h00, 8'h02);
        expect_out("addc_after_ill", {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
        drain();

        // back-pressure: output stalled three cycles
        OUT_READY = 1'b0;
        fill2();
        IN_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("stall_in_ready", IN_READY, 0);
            chk("stall_out_valid", OUT_VALID, 1);
            step();
        end
        OUT_READY = 1'b1;
        stream(12);
        drain();

        // enable gating
        OUT_READY = 1'b0;
        fill2();
        ENABLE = 1'b0;
        step();
        chk("en_off_in_ready", IN_READY, 0);
        OUT_READY = 1'b1;
        step();
        chk("en_off_drained", OUT_VALID, 0);
        chk("en_off_in_ready2", IN_READY, 0);
        step();
        chk("en_off_s1_held", OUT_VALID, 0);
        ENABLE = 1'b1;
        step();
        chk("en_on_in_ready", IN_READY, 1);
        chk("en_on_not_yet", OUT_VALID, 0);
        step();
        chk("en_on_resumed", OUT_VALID, 1);
        drain();

        // reset with both stages full
        OUT_READY = 1'b0;
        fill2();
        RST_N = 1'b0;
        step();
        chk("midrst_out_valid", OUT_VALID, 0);
        chk("midrst_in_ready", IN_READY, 0);
        RST_N = 1'b1;
        OUT_READY = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("midrst_no_stale", OUT_VALID, 0);
        end

        // randomized traffic
        IN_VALID = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(negedge CLK);
            f = IN_VALID && IN_READY;
            step();
            ENABLE    = ($urandom_range(0, 9) != 0);
            OUT_READY = ($urandom_range(0, 3) != 0);
            RST_N     = (i != 400);
            if (f || !IN_VALID) begin
                IN_VALID = ($urandom_range(0, 2) != 0);
                new_beat();
            end
        end
        RST_N = 1'b1;
        IN_VALID = 1'b0;
        ENABLE = 1'b1;
        OUT_READY = 1'b1;
        repeat (10) step();
        chk("sb_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
